// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable serial pattern detector:
//   - seq_state_e  : detector state (DISABLED / FILLING / ARMED)
//   - calc_len_w   : width of the pattern-length field for a given MAX_LEN
//   - len_is_valid : checks that a programmed length is in 1..MAX_LEN
// Optional feature macro used by the top level: SEQDET_MATCH_COUNT_EN
// -----------------------------------------------------------------------------
package seq_det_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'b00,
    FILLING  = 2'b01,
    ARMED    = 2'b10
  } seq_state_e;

  // Enough bits to hold the values 0..max_len.
  function automatic int unsigned calc_len_w(input int unsigned max_len);
    return int'($clog2(max_len + 1));
  endfunction

  function automatic logic len_is_valid(input int unsigned len,
                                        input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// -----------------------------------------------------------------------------
// seq_det_match
// Combinational masked comparison of the history shift register against the
// programmed pattern. Only the lowest i_len bits take part; higher bits are
// don't-care so that shorter patterns can live in the MAX_LEN-wide registers.
// Ports:
//   i_hist    [MAX_LEN-1:0]  history, bit [0] = most recent sample
//   i_pattern [MAX_LEN-1:0]  pattern, LSB-aligned
//   i_len     [LEN_W-1:0]    active pattern length
//   o_eq                     1 when the low i_len bits are equal
// -----------------------------------------------------------------------------
module seq_det_match #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] i_hist,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_eq
);

  logic [MAX_LEN-1:0] w_mask;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  assign o_eq = (((i_hist ^ i_pattern) & w_mask) == '0);

endmodule

// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
// Runtime-programmable serial pattern detector (1..MAX_LEN bits), overlapping
// or non-overlapping matching, registered one-cycle match pulse.
// Optional feature: define SEQDET_MATCH_COUNT_EN to add a saturating match
// counter on port match_count.
//
// State | meaning
// ------+---------------------------------------------------------
// DISABLED | programmed length invalid; samples ignored, y held 0
// FILLING  | fewer than len samples collected since last clear
// ARMED    | len samples collected; every new sample can complete a match
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   in_valid, a           qualified serial input bit
//   cfg_load              latch cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern           pattern, bit [len-1] = first bit received
//   cfg_len               pattern length (valid range 1..MAX_LEN)
//   cfg_overlap           1: overlapping matches, 0: non-overlapping
//   y                     registered match pulse
//   cfg_err               current configuration invalid
//   match_count           saturating match count (SEQDET_MATCH_COUNT_EN only)
// -----------------------------------------------------------------------------
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         CNT_W       = 16,
  parameter logic [MAX_LEN-1:0]  RST_PATTERN = 8'b0000_1101,
  parameter int unsigned         RST_LEN     = 4,
  parameter logic                RST_OVERLAP = 1'b1,
  localparam int unsigned        LEN_W       = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               a,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic               cfg_err
`ifdef SEQDET_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  seq_state_e         r_state;
  logic               r_y;
  logic               r_cfg_err;

  logic               w_cfg_valid;
  logic               w_sample;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W:0]     w_fill_inc;
  logic               w_full;
  logic               w_eq;
  logic               w_match;
  logic [LEN_W-1:0]   w_fill_next;
  seq_state_e         w_state_next;

  assign w_cfg_valid = len_is_valid(32'(cfg_len), MAX_LEN);

  // cfg_load wins over a simultaneous sample; a disabled detector ignores data.
  assign w_sample    = in_valid && !cfg_load && (r_state != DISABLED);
  assign w_hist_next = {r_hist[MAX_LEN-2:0], a};

  // One extra bit so fill+1 cannot wrap when len == 2**LEN_W - 1.
  assign w_fill_inc  = {1'b0, r_fill} + 1'b1;
  assign w_full      = (w_fill_inc >= {1'b0, r_len});

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .i_hist    (w_hist_next),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_eq      (w_eq)
  );

  assign w_match = w_sample && w_full && w_eq;

  // Non-overlap restarts collection after a hit; otherwise fill saturates at len.
  always_comb begin
    w_fill_next = w_full ? r_len : w_fill_inc[LEN_W-1:0];
    if (w_match && !r_overlap) begin
      w_fill_next = '0;
    end
    w_state_next = (w_fill_next == r_len) ? ARMED : FILLING;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern <= RST_PATTERN;
      r_len     <= LEN_W'(RST_LEN);
      r_overlap <= RST_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= FILLING;
      r_y       <= 1'b0;
      r_cfg_err <= 1'b0;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_len     <= cfg_len;
      r_overlap <= cfg_overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= w_cfg_valid ? FILLING : DISABLED;
      r_y       <= 1'b0;
      r_cfg_err <= !w_cfg_valid;
    end else begin
      r_y <= w_match;
      if (w_sample) begin
        r_hist  <= w_hist_next;
        r_fill  <= w_fill_next;
        r_state <= w_state_next;
      end
    end
  end

  assign y       = r_y;
  assign cfg_err = r_cfg_err;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_match_count;

  // Advances on the same edge that raises y, so it tracks y pulses exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match_count <= '0;
    end else if (cfg_load) begin
      r_match_count <= '0;
    end else if (w_match && (r_match_count != {CNT_W{1'b1}})) begin
      r_match_count <= r_match_count + 1'b1;
    end
  end

  assign match_count = r_match_count;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       a;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       y;
  logic       cfg_err;
`ifdef SEQDET_MATCH_COUNT_EN
  logic [1:0] match_count;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int n_pulses = 0;

  // Reference model: bits received since the last clear, and how many of
  // them are still usable for the next match (reset by a non-overlap hit).
  logic       hist_q[$];
  int         since;
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ov;
  logic       m_err;
  logic       exp_y;
  int         exp_cnt;

  always #5 clk = ~clk;

  seq_detector_prog #(.CNT_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .a           (a),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .y           (y),
    .cfg_err     (cfg_err)
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = 8'b0000_1101;
    m_len = 4;
    m_ov  = 1'b1;
    m_err = 1'b0;
    hist_q.delete();
    since   = 0;
    exp_y   = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [7:0] p, input logic [3:0] l, input logic ov);
    logic hit;
    @(negedge clk);
    in_valid = v; a = b; cfg_load = ld;
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    exp_y = 1'b0;
    if (ld) begin
      m_pat = p; m_len = int'(l); m_ov = ov;
      m_err = (l == 0) || (l > 8);
      hist_q.delete();
      since = 0;
      exp_cnt = 0;
    end else if (v && !m_err) begin
      hist_q.push_back(b);
      since++;
      if (since >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (hist_q[hist_q.size()-1-i] !== m_pat[i]) hit = 1'b0;
        if (hit) begin
          exp_y = 1'b1;
          if (!m_ov) since = 0;
          if (exp_cnt < 3) exp_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    check("y", {31'd0, y}, {31'd0, exp_y});
    check("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
`ifdef SEQDET_MATCH_COUNT_EN
    check("match_count", {30'd0, match_count}, exp_cnt);
`endif
    if (y === 1'b1) n_pulses++;
  endtask

  task automatic samp(input logic b);  step(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0); endtask
  task automatic idle();               step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0); endtask
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    step(1'b0, 1'b0, 1'b1, p, l, ov);
  endtask

  // Sends bits[n-1] first.
  task automatic stream(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) samp(bits[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; cfg_load = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_y", {31'd0, y}, 32'd0);
    check("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    model_reset();
    #12;
    check("rst_y", {31'd0, y}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Default 1101 overlapping on 1101101
    n_pulses = 0;
    stream(32'b1101101, 7);
    check("default_pulses", n_pulses, 2);

    // 11, len 2, non-overlap then overlap, on 1111
    load(8'b11, 4'd2, 1'b0);
    n_pulses = 0;
    stream(32'b1111, 4);
    check("nonoverlap_pulses", n_pulses, 2);
    load(8'b11, 4'd2, 1'b1);
    n_pulses = 0;
    stream(32'b1111, 4);
    check("overlap_pulses", n_pulses, 3);

    // Default pattern with gaps in in_valid
    load(8'b0000_1101, 4'd4, 1'b1);
    n_pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] pb;
      pb = 4'b1101;
      samp(pb[i]);
      if (i != 0) begin idle(); idle(); end
    end
    idle(); idle();
    check("gapped_pulses", n_pulses, 1);

    // Invalid lengths
    n_pulses = 0;
    load(8'b0000_0001, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) samp(1'b1);
    load(8'b1111_1111, 4'd9, 1'b1);
    for (int i = 0; i < 20; i++) samp(1'b1);
    check("invalid_pulses", n_pulses, 0);
    load(8'b0000_1101, 4'd4, 1'b1);
    n_pulses = 0;
    stream(32'b1101, 4);
    check("reload_pulses", n_pulses, 1);

    // Reset mid-sequence, then cfg_load mid-pattern
    n_pulses = 0;
    stream(32'b110, 3);
    do_reset();
    samp(1'b1);
    check("after_reset_pulses", n_pulses, 0);
    stream(32'b1101, 4);
    check("fresh_pattern_pulses", n_pulses, 1);
    n_pulses = 0;
    stream(32'b11, 2);
    load(8'b0000_1101, 4'd4, 1'b1);
    stream(32'b01, 2);
    check("load_mid_pulses", n_pulses, 0);

`ifdef SEQDET_MATCH_COUNT_EN
    load(8'b0000_1101, 4'd4, 1'b1);
    stream(32'b1101101101101101, 16);
    check("count_sat", {30'd0, match_count}, 32'd3);
    load(8'b0000_1101, 4'd4, 1'b1);
    check("count_clear", {30'd0, match_count}, 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        logic [3:0] rl;
        if ($urandom_range(0, 4) == 0) rl = 4'($urandom_range(0, 9));
        else rl = 4'($urandom_range(1, 3));
        load(8'($urandom), rl, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0,
             8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
